// File: rtl/bytecode_insn_assembler_if.sv
// Byte-fetch and assembled-instruction handshake bundle for the bytecode assembler.
// The master modport is the assembler side; the slave modport is the fetch/decode environment.
interface bytecode_insn_assembler_if #(
   parameter int ADDRESS_WIDTH = 8
);
   logic [7:0]               byte_in;
   logic                     byte_ready;
   logic                     byte_start;
   logic                     insn_valid;
   logic                     insn_accept;
   logic [7:0]               insn_opcode;
   logic [15:0]              insn_operand;
   logic [1:0]               insn_len;
   logic [ADDRESS_WIDTH-1:0] insn_pc;
   logic                     insn_illegal;

   modport master (
      input  byte_in, byte_ready, insn_accept,
      output byte_start, insn_valid, insn_opcode, insn_operand, insn_len, insn_pc, insn_illegal
   );

   modport slave (
      output byte_in, byte_ready, insn_accept,
      input  byte_start, insn_valid, insn_opcode, insn_operand, insn_len, insn_pc, insn_illegal
   );
endinterface

// File: rtl/bytecode_insn_assembler.sv
// Pulls bytecode one byte at a time and assembles opcode + 0/1/2-byte big-endian operand,
// presenting each instruction with its opcode address until downstream accepts it.
module bytecode_insn_assembler #(
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     pc_reset,
   input  logic [ADDRESS_WIDTH-1:0] pc_reset_value,
   input  logic                     flush,
   input  logic [ADDRESS_WIDTH-1:0] flush_pc,
   bytecode_insn_assembler_if.master bus
);

   typedef enum logic [1:0] {FETCH_OP, FETCH_B1, FETCH_B2, EMIT} state_t;
   typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_TWO, CLS_ILLEGAL} cls_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] pc;
   cls_t                     op_cls;
   logic                     handshake;

   always_comb begin
      op_cls = CLS_NONE;
      case (bus.byte_in) inside
         8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5, 8'hC8, 8'hC9:
            op_cls = CLS_ILLEGAL;
         8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
            op_cls = CLS_ONE;
         8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
         8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
            op_cls = CLS_TWO;
         default:
            op_cls = CLS_NONE;
      endcase
   end

   assign bus.byte_start = (state != EMIT);
   assign handshake      = bus.byte_start & bus.byte_ready;

   always_ff @(posedge clk or negedge pc_reset) begin
      if (!pc_reset) begin
         state            <= FETCH_OP;
         pc               <= pc_reset_value;
         bus.insn_valid   <= 1'b0;
         bus.insn_opcode  <= '0;
         bus.insn_operand <= '0;
         bus.insn_len     <= '0;
         bus.insn_pc      <= '0;
         bus.insn_illegal <= 1'b0;
      end else if (flush) begin
         // redirect wins over accept and over any byte handshaken this cycle
         state          <= FETCH_OP;
         pc             <= flush_pc;
         bus.insn_valid <= 1'b0;
      end else begin
         case (state)
            FETCH_OP: begin
               if (handshake) begin
                  pc               <= pc + ADDRESS_WIDTH'(1);
                  bus.insn_opcode  <= bus.byte_in;
                  bus.insn_pc      <= pc;
                  bus.insn_operand <= '0;
                  bus.insn_illegal <= 1'b0;
                  case (op_cls)
                     CLS_ONE: begin
                        bus.insn_len <= 2'd2;
                        state        <= FETCH_B1;
                     end
                     CLS_TWO: begin
                        bus.insn_len <= 2'd3;
                        state        <= FETCH_B1;
                     end
                     CLS_ILLEGAL: begin
                        bus.insn_len     <= 2'd1;
                        bus.insn_illegal <= 1'b1;
                        bus.insn_valid   <= 1'b1;
                        state            <= EMIT;
                     end
                     default: begin
                        bus.insn_len   <= 2'd1;
                        bus.insn_valid <= 1'b1;
                        state          <= EMIT;
                     end
                  endcase
               end
            end
            FETCH_B1: begin
               if (handshake) begin
                  pc <= pc + ADDRESS_WIDTH'(1);
                  // the latched length tells which operand class this opcode belongs to
                  if (bus.insn_len == 2'd3) begin
                     bus.insn_operand[15:8] <= bus.byte_in;
                     state                  <= FETCH_B2;
                  end else begin
                     bus.insn_operand <= {8'h00, bus.byte_in};
                     bus.insn_valid   <= 1'b1;
                     state            <= EMIT;
                  end
               end
            end
            FETCH_B2: begin
               if (handshake) begin
                  pc                    <= pc + ADDRESS_WIDTH'(1);
                  bus.insn_operand[7:0] <= bus.byte_in;
                  bus.insn_valid        <= 1'b1;
                  state                 <= EMIT;
               end
            end
            EMIT: begin
               if (bus.insn_accept) begin
                  bus.insn_valid <= 1'b0;
                  state          <= FETCH_OP;
               end
            end
            default: state <= FETCH_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_bytecode_insn_assembler.sv
// Scoreboard bench: stimulus pushes expected instructions, a monitor pops them on accept.
module tb_bytecode_insn_assembler;
   localparam int AW = 8;

   typedef struct packed {
      logic [7:0]    op;
      logic [15:0]   operand;
      logic [1:0]    len;
      logic [AW-1:0] pc;
      logic          ill;
   } exp_t;

   logic          clk = 1'b0;
   logic          pc_reset = 1'b1;
   logic [AW-1:0] pc_reset_value = 8'h10;
   logic          flush = 1'b0;
   logic [AW-1:0] flush_pc = '0;
   logic          accept_en = 1'b1;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   exp_t          exp_q[$];
   logic [AW-1:0] model_pc;

   bytecode_insn_assembler_if #(.ADDRESS_WIDTH(AW)) bus ();

   bytecode_insn_assembler #(.ADDRESS_WIDTH(AW)) dut (
      .clk            (clk),
      .pc_reset       (pc_reset),
      .pc_reset_value (pc_reset_value),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .bus            (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   // operand count from the opcode tables; -1 marks an unsupported opcode
   function automatic int n_ops(input logic [7:0] op);
      if (op inside {8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5, 8'hC8, 8'hC9}) return -1;
      if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC}) return 1;
      if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
                     8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7}) return 2;
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   initial begin
      bus.insn_accept = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.insn_accept = accept_en && ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: every valid cycle must present the oldest outstanding instruction
   initial begin
      exp_t act;
      forever begin
         @(negedge clk);
         if (pc_reset) begin
            check("byte_start_vs_valid", {31'd0, bus.byte_start}, {31'd0, !bus.insn_valid});
            if (bus.insn_valid) begin
               act = '{bus.insn_opcode, bus.insn_operand, bus.insn_len, bus.insn_pc, bus.insn_illegal};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_insn: got op=%h opnd=%h len=%0d pc=%h ill=%b expected none",
                           act.op, act.operand, act.len, act.pc, act.ill);
               end else if (act !== exp_q[0]) begin
                  errors++;
                  $display("FAIL insn: got op=%h opnd=%h len=%0d pc=%h ill=%b expected op=%h opnd=%h len=%0d pc=%h ill=%b",
                           act.op, act.operand, act.len, act.pc, act.ill, exp_q[0].op,
                           exp_q[0].operand, exp_q[0].len, exp_q[0].pc, exp_q[0].ill);
               end
               if (bus.insn_accept && exp_q.size() != 0) void'(exp_q.pop_front());
            end
         end
      end
   end

   // offer byte b after g cycles of byte_ready=0; returns just before the consuming edge
   task automatic feed(input logic [7:0] b, input int unsigned g);
      int unsigned gaps = 0;
      for (int unsigned cnt = 0; cnt < 300; cnt++) begin
         @(negedge clk);
         bus.byte_in = b;
         if (!bus.byte_start) bus.byte_ready = 1'b0;
         else if (gaps < g) begin
            bus.byte_ready = 1'b0;
            gaps++;
         end else begin
            bus.byte_ready = 1'b1;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL feed_timeout: byte_start stayed 0 for 300 cycles, expected 1");
   endtask

   task automatic idle();
      @(posedge clk);
      #1 bus.byte_ready = 1'b0;
   endtask

   task automatic send_insn(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                            input int unsigned g_op, input int unsigned g_opnd);
      exp_t e;
      int   n = n_ops(op);
      e.op      = op;
      e.pc      = model_pc;
      e.ill     = (n < 0);
      e.len     = (n < 0) ? 2'd1 : 2'(n + 1);
      e.operand = (n == 1) ? {8'h00, b1} : (n == 2) ? {b1, b2} : 16'h0000;
      exp_q.push_back(e);
      model_pc = model_pc + AW'(e.len);
      feed(op, g_op);
      if (n >= 1) feed(b1, g_opnd);
      if (n == 2) feed(b2, g_opnd);
      idle();
   endtask

   task automatic drain();
      for (int unsigned cnt = 0; cnt < 500; cnt++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.insn_valid) return;
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d instructions outstanding, expected 0", exp_q.size());
   endtask

   task automatic do_flush(input logic [AW-1:0] pc, input logic with_byte);
      @(negedge clk);
      flush          = 1'b1;
      flush_pc       = pc;
      bus.byte_in    = 8'h12;
      bus.byte_ready = with_byte;
      @(posedge clk);
      #1;
      flush          = 1'b0;
      bus.byte_ready = 1'b0;
      model_pc       = pc;
   endtask

   initial begin
      bus.byte_in    = '0;
      bus.byte_ready = 1'b0;
      #2 pc_reset = 1'b0;
      #20;
      check("rst_valid",   {31'd0, bus.insn_valid},   32'd0);
      check("rst_opcode",  {24'd0, bus.insn_opcode},  32'd0);
      check("rst_operand", {16'd0, bus.insn_operand}, 32'd0);
      check("rst_len",     {30'd0, bus.insn_len},     32'd0);
      check("rst_pc",      {24'd0, bus.insn_pc},      32'd0);
      check("rst_illegal", {31'd0, bus.insn_illegal}, 32'd0);
      check("rst_start",   {31'd0, bus.byte_start},   32'd1);
      @(negedge clk);
      pc_reset = 1'b1;
      model_pc = 8'h10;

      send_insn(8'h04, 8'h00, 8'h00, 0, 0);   // iconst_1
      send_insn(8'h11, 8'h12, 8'h34, 0, 0);   // sipush 0x1234
      send_insn(8'h10, 8'hFF, 8'h00, 0, 2);   // bipush with two idle ready cycles
      send_insn(8'hAA, 8'h00, 8'h00, 0, 0);   // illegal
      send_insn(8'h04, 8'h00, 8'h00, 0, 0);
      drain();

      accept_en = 1'b0;
      send_insn(8'h00, 8'h00, 8'h00, 0, 0);
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, bus.insn_valid}, 32'd1);
         check("hold_start", {31'd0, bus.byte_start}, 32'd0);
      end
      accept_en = 1'b1;
      drain();

      // goto partially fetched, flushed while its last byte is handshaken
      feed(8'hA7, 0);
      feed(8'h00, 0);
      idle();
      do_flush(8'h40, 1'b1);
      repeat (4) @(negedge clk);
      check("flush_no_valid", {31'd0, bus.insn_valid}, 32'd0);
      send_insn(8'h04, 8'h00, 8'h00, 0, 0);
      drain();

      do_flush(8'hFF, 1'b0);
      send_insn(8'h11, 8'hAB, 8'hCD, 0, 0);
      send_insn(8'h04, 8'h00, 8'h00, 0, 0);
      drain();

      // async reset mid-instruction drops the partial sipush
      feed(8'h11, 0);
      feed(8'h12, 0);
      idle();
      @(negedge clk);
      pc_reset_value = 8'h80;
      pc_reset       = 1'b0;
      #1;
      check("mid_rst_valid",   {31'd0, bus.insn_valid},   32'd0);
      check("mid_rst_operand", {16'd0, bus.insn_operand}, 32'd0);
      @(negedge clk);
      pc_reset = 1'b1;
      model_pc = 8'h80;
      send_insn(8'h84, 8'h05, 8'hFE, 0, 1);
      drain();

      for (int unsigned i = 0; i < 150; i++) begin
         send_insn(8'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
